// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package divider_pkg;

   localparam int DW_DEF = 32;
   localparam int VW_DEF = 16;
   localparam int CNT_W  = $clog2(DW_DEF);

   // Quotient reported when the divisor is zero.
   localparam logic [DW_DEF-1:0] DBZ_QUOT = {DW_DEF{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step #(
   parameter int VW = 16
) (
   input  logic [VW:0]   pr_in,
   input  logic          next_bit,
   input  logic [VW-1:0] divisor,
   output logic [VW:0]   pr_out,
   output logic          q_bit
);

   logic [VW+1:0] shifted;
   logic [VW+1:0] diff;

   // The partial remainder stays below the divisor, so the shifted value fits
   // in VW+1 bits and the top bit of the VW+2-bit difference is the borrow.
   always_comb begin
      shifted = {pr_in, next_bit};
      diff    = shifted - {2'b00, divisor};
      q_bit   = ~diff[VW+1];
      pr_out  = q_bit ? diff[VW:0] : shifted[VW:0];
   end

endmodule

// File: rtl/seq_divider_32by16.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on
// both the operand and the result side.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high once out of reset
// BUSY  | DW restoring steps, one per cycle, counter runs DW-1 down to 0
// DONE  | result presented with out_valid, frozen until out_ready
module seq_divider_32by16
   import divider_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW);

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [DW-1:0]   q_sh_q;
   logic [VW:0]     pr_q;
   logic [VW-1:0]   dvs_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [DW-1:0]   quotient_q;
   logic [VW-1:0]   remainder_q;
   logic            dbz_q;

   logic [VW:0]     pr_d;
   logic            qbit_d;

   div_step #(.VW(VW)) u_step (
      .pr_in    (pr_q),
      .next_bit (q_sh_q[DW-1]),
      .divisor  (dvs_q),
      .pr_out   (pr_d),
      .q_bit    (qbit_d)
   );

   // FSM, counter, datapath registers and registered outputs. in_ready comes
   // up on the first clock after reset release and gates the accept itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         q_sh_q      <= '0;
         pr_q        <= '0;
         dvs_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  q_sh_q     <= dividend;
                  dvs_q      <= divisor;
                  if (divisor != '0) begin
                     pr_q    <= '0;
                     cnt_q   <= CW'(DW - 1);
                     state_q <= BUSY;
                  end else begin
                     quotient_q  <= '1;
                     remainder_q <= dividend[VW-1:0];
                     dbz_q       <= 1'b1;
                     out_valid_q <= 1'b1;
                     state_q     <= DONE;
                  end
               end
            end
            BUSY: begin
               pr_q   <= pr_d;
               q_sh_q <= {q_sh_q[DW-2:0], qbit_d};
               if (cnt_q == '0) begin
                  quotient_q  <= {q_sh_q[DW-2:0], qbit_d};
                  remainder_q <= pr_d[VW-1:0];
                  dbz_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32by16.sv
// Directed bench for seq_divider_32by16.
module tb_seq_divider_32by16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int total = 0;
   int bad   = 0;

   seq_divider_32by16 #(.DW(32), .VW(16)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_div(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                         input logic [31:0] eq, input logic [15:0] er, input logic edz,
                         input int elat, input bit pulse, input int hold);
      int n;
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      tick();
      in_valid = 1'b0;
      dividend = $urandom;
      divisor  = 16'($urandom);
      n = 0;
      while (!out_valid && n < 100) begin
         if (pulse) in_valid = (n % 3 == 1);
         tick();
         n++;
      end
      in_valid = 1'b0;
      chk({tag, ".latency"}, 64'(n), 64'(elat));
      chk({tag, ".quotient"}, 64'(quotient), 64'(eq));
      chk({tag, ".remainder"}, 64'(remainder), 64'(er));
      chk({tag, ".dbz"}, 64'(div_by_zero), 64'(edz));
      chk({tag, ".busy_rdy"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, ".stall"}, {13'd0, out_valid, in_ready, div_by_zero, remainder, quotient},
             {13'd0, 1'b1, 1'b0, edz, er, eq});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, ".post_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".post_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      #3;
      chk("rst.outputs", {13'd0, out_valid, in_ready, div_by_zero, remainder, quotient}, 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst.in_ready", 64'(in_ready), 64'd1);

      // Multiplier round trips and general cases
      do_div("sq65535",  32'd4294836225, 16'd65535, 32'd65535,      16'd0, 1'b0, 32, 1'b0, 0);
      do_div("one",      32'd1,          16'd1,     32'd1,          16'd0, 1'b0, 32, 1'b0, 0);
      do_div("nine",     32'd9,          16'd3,     32'd3,          16'd0, 1'b0, 32, 1'b0, 0);
      do_div("d100_7",   32'd100,        16'd7,     32'd14,         16'd2, 1'b0, 32, 1'b0, 0);
      do_div("d5_9",     32'd5,          16'd9,     32'd0,          16'd5, 1'b0, 32, 1'b0, 0);
      do_div("max_1",    32'hFFFFFFFF,   16'd1,     32'hFFFFFFFF,   16'd0, 1'b0, 32, 1'b0, 0);
      do_div("max_max",  32'hFFFFFFFF,   16'hFFFF,  32'h00010001,   16'd0, 1'b0, 32, 1'b0, 0);

      // Backpressure with in_valid noise while busy
      do_div("bp",       32'd123456789,  16'd12345, 32'd10000,      16'd6789, 1'b0, 32, 1'b1, 5);

      // Divide by zero, result visible right after the accept edge
      do_div("dbz",      32'd1234,       16'd0,     32'hFFFFFFFF,   16'd1234, 1'b1, 0, 1'b0, 2);

      // Reset ten cycles into BUSY; previous dbz result must clear asynchronously
      in_valid = 1'b1;
      dividend = 32'd100;
      divisor  = 16'd7;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.outputs", {13'd0, out_valid, in_ready, div_by_zero, remainder, quotient}, 64'd0);
      tick();
      rst_n = 1'b1;
      do_div("after_rst", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32, 1'b0, 0);

      // Back-to-back with out_ready tied high; second operands held from the start
      out_ready = 1'b1;
      in_valid  = 1'b1;
      dividend  = 32'd1000;
      divisor   = 16'd33;
      tick();
      dividend  = 32'd196613;
      divisor   = 16'd256;
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("b2b.lat1", 64'(n), 64'd32);
      chk("b2b.q1", {16'd0, remainder, quotient}, {16'd0, 16'd10, 32'd30});
      tick();
      chk("b2b.handshake", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
      tick();
      in_valid = 1'b0;
      chk("b2b.accept2", 64'(in_ready), 64'd0);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("b2b.lat2", 64'(n), 64'd32);
      chk("b2b.q2", {16'd0, remainder, quotient}, {16'd0, 16'd5, 32'd768});
      tick();
      out_ready = 1'b0;
      chk("b2b.done", 64'(out_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
